// File: rtl/counter_match_sequencer.sv
// Two-player move sequencer around a shared up/down counter and its win/lose match tracker.
// Optional macro FIXED_PRIO_EN: player 0 always wins simultaneous requests (no round-robin pointer).
module counter_match_sequencer #(
  parameter int N         = 4,
  parameter int MAX_MOVES = 64,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       seed,
  input  logic [1:0]         req,
  input  logic [3:0]         req_mode,
  output logic [1:0]         gnt,
  output logic               cnt_init,
  output logic [N-1:0]       cnt_val,
  output logic [1:0]         cnt_ctrl,
  input  logic [N-1:0]       cnt_count,
  input  logic               winner,
  input  logic               loser,
  input  logic               gameover,
  input  logic [1:0]         who,
  output logic               busy,
  output logic               match_done,
  output logic [1:0]         champ,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1
);

  localparam int                 MCW        = 1 + $clog2(MAX_MOVES);
  localparam logic [MCW-1:0]     MOVE_LIMIT = MCW'(MAX_MOVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARB,
    S_STEP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [MCW-1:0]     move_cnt;
  logic [1:0]         mode_q;
  logic               player_q;
  logic               wait_ph;
  logic               win_seen, lose_seen, go_seen;
  logic [1:0]         who_q;

  logic               sel, grant, wait_last, end_go, end_limit, match_start;
  logic               win_any, lose_any, go_any;
  logic [1:0]         who_eff, champ_go, champ_lim;
  logic [SCORE_W-1:0] score_sel, score_adj, score0_nxt, score1_nxt;

  // Arbitration: sel names the player granted when req != 0.
`ifdef FIXED_PRIO_EN
  assign sel = ~req[0];
`else
  logic ptr;

  assign sel = (req == 2'b11) ? ptr : req[1];

  always_ff @(posedge clk) begin
    if (rst)        ptr <= 1'b0;
    else if (grant) ptr <= ~sel;
  end
`endif

  assign match_start = (state == S_IDLE) && start;

  // Event flags fold the live inputs into what was already seen earlier in the window.
  assign win_any  = win_seen | winner;
  assign lose_any = lose_seen | loser;
  assign go_any   = go_seen | gameover;
  assign who_eff  = go_seen ? who_q : who;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    gnt        = 2'b00;
    cnt_init   = 1'b1;
    cnt_val    = cnt_count;
    cnt_ctrl   = 2'b00;
    grant      = 1'b0;
    wait_last  = 1'b0;
    end_go     = 1'b0;
    end_limit  = 1'b0;

    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        cnt_val   = seed;
        state_nxt = S_ARB;
      end
      S_ARB: begin
        if (gameover) begin
          end_go    = 1'b1;
          state_nxt = S_DONE;
        end else if (req != 2'b00) begin
          grant     = 1'b1;
          gnt       = sel ? 2'b10 : 2'b01;
          state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        cnt_init  = 1'b0;
        cnt_ctrl  = mode_q;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_ph) begin
          wait_last = 1'b1;
          if (go_any) begin
            end_go    = 1'b1;
            state_nxt = S_DONE;
          end else if (move_cnt == MOVE_LIMIT) begin
            end_limit = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ARB;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One credit per move, applied as the WAIT window closes; winner beats loser.
  always_comb begin
    score_sel = player_q ? score1 : score0;
    score_adj = score_sel;
    if (win_any) begin
      if (score_sel != SCORE_MAX) score_adj = score_sel + 1'b1;
    end else if (lose_any) begin
      if (score_sel != '0) score_adj = score_sel - 1'b1;
    end

    score0_nxt = score0;
    score1_nxt = score1;
    if (match_start) begin
      score0_nxt = '0;
      score1_nxt = '0;
    end else if (wait_last) begin
      if (player_q) score1_nxt = score_adj;
      else          score0_nxt = score_adj;
    end
  end

  always_comb begin
    case (who_eff)
      2'b01:   champ_go = player_q ? 2'b10 : 2'b01;
      2'b10:   champ_go = player_q ? 2'b01 : 2'b10;
      default: champ_go = 2'b11;
    endcase

    if (score0_nxt > score1_nxt)      champ_lim = 2'b01;
    else if (score1_nxt > score0_nxt) champ_lim = 2'b10;
    else                              champ_lim = 2'b11;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      move_cnt  <= '0;
      mode_q    <= 2'b00;
      player_q  <= 1'b0;
      wait_ph   <= 1'b0;
      win_seen  <= 1'b0;
      lose_seen <= 1'b0;
      go_seen   <= 1'b0;
      who_q     <= 2'b00;
      champ     <= 2'b00;
      score0    <= '0;
      score1    <= '0;
    end else begin
      state  <= state_nxt;
      score0 <= score0_nxt;
      score1 <= score1_nxt;

      if (match_start) begin
        move_cnt  <= '0;
        champ     <= 2'b00;
        win_seen  <= 1'b0;
        lose_seen <= 1'b0;
        go_seen   <= 1'b0;
      end

      if (grant) begin
        mode_q   <= sel ? req_mode[3:2] : req_mode[1:0];
        player_q <= sel;
      end

      if (state == S_STEP) begin
        if (move_cnt != MOVE_LIMIT) move_cnt <= move_cnt + 1'b1;
        wait_ph   <= 1'b0;
        win_seen  <= 1'b0;
        lose_seen <= 1'b0;
        go_seen   <= 1'b0;
      end

      if (state == S_WAIT) begin
        wait_ph   <= 1'b1;
        win_seen  <= win_any;
        lose_seen <= lose_any;
        go_seen   <= go_any;
        who_q     <= who_eff;
      end

      if (end_go)         champ <= champ_go;
      else if (end_limit) champ <= champ_lim;
    end
  end

  assign busy       = (state != S_IDLE);
  assign match_done = (state == S_DONE);

endmodule

// File: tb/tb_counter_match_sequencer.sv
// Self-checking bench for counter_match_sequencer: directed matches plus randomized matches
// checked against a move-level model (arbitration, counter arithmetic, scores, champion).
module tb_counter_match_sequencer;

  localparam int N         = 4;
  localparam int MAX_MOVES = 4;
  localparam int SCORE_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [N-1:0]       seed = '0;
  logic [1:0]         req = 2'b00;
  logic [3:0]         req_mode = 4'h0;
  logic [1:0]         gnt;
  logic               cnt_init;
  logic [N-1:0]       cnt_val;
  logic [1:0]         cnt_ctrl;
  logic [N-1:0]       cnt_count;
  logic               winner, loser;
  logic               gameover = 1'b0;
  logic [1:0]         who = 2'b00;
  logic               busy, match_done;
  logic [1:0]         champ;
  logic [SCORE_W-1:0] score0, score1;

  counter_match_sequencer #(.N(N), .MAX_MOVES(MAX_MOVES), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .req(req), .req_mode(req_mode),
    .gnt(gnt), .cnt_init(cnt_init), .cnt_val(cnt_val), .cnt_ctrl(cnt_ctrl),
    .cnt_count(cnt_count), .winner(winner), .loser(loser), .gameover(gameover), .who(who),
    .busy(busy), .match_done(match_done), .champ(champ), .score0(score0), .score1(score1)
  );

  always #5 clk = ~clk;

  // Counter datapath the sequencer drives: 00 up, 01 down, others hold.
  logic [N-1:0] cnt_q;
  always @(posedge clk) begin
    if (rst)           cnt_q <= '0;
    else if (cnt_init) cnt_q <= cnt_val;
    else if (cnt_ctrl == 2'b00) cnt_q <= cnt_q + 1'b1;
    else if (cnt_ctrl == 2'b01) cnt_q <= cnt_q - 1'b1;
  end
  assign cnt_count = cnt_q;
  assign winner    = &cnt_q;
  assign loser     = (cnt_q == '0);

  int checks = 0;
  int errors = 0;

  // Move-level reference model state.
  int         ptr_m = 0;
  int         last_p = 0;
  int         cnt_m = 0;
  int         s0_m = 0;
  int         s1_m = 0;
  int         moves_m = 0;
  logic [1:0] champ_m = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] champ_by_who(input logic [1:0] w, input int p);
    if (w == 2'b01) return (p == 1) ? 2'b10 : 2'b01;
    if (w == 2'b10) return (p == 1) ? 2'b01 : 2'b10;
    return 2'b11;
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > (1 << SCORE_W) - 1) return (1 << SCORE_W) - 1;
    return v;
  endfunction

  task automatic model_reset();
    ptr_m = 0; last_p = 0; cnt_m = 0; s0_m = 0; s1_m = 0; moves_m = 0; champ_m = 2'b00;
  endtask

  task automatic start_match(input logic [3:0] s);
    req   = 2'b00;
    start = 1'b1;
    seed  = s;
    tick();
    start = 1'b0;
    cnt_m = int'(s); s0_m = 0; s1_m = 0; moves_m = 0; champ_m = 2'b00;
    check("load_init", 32'(cnt_init), 32'(1'b1));
    check("load_val", 32'(cnt_val), 32'(s));
    check("load_busy", 32'(busy), 32'(1'b1));
    check("load_scores", {16'h0, 8'(score0), 8'(score1)}, 32'h0);
    check("load_champ", 32'(champ), 32'h0);
    tick();
    check("arb_count", 32'(cnt_count), 32'(cnt_m));
    check("arb_freeze", 32'({cnt_init, cnt_val}), 32'({1'b1, cnt_count}));
    check("arb_gnt_idle", 32'(gnt), 32'h0);
  endtask

  task automatic finish_match(input string tag);
    check({tag, "_done"}, 32'(match_done), 32'(1'b1));
    check({tag, "_champ"}, 32'(champ), 32'(champ_m));
    req = 2'b00;
    tick();
    check({tag, "_done_end"}, 32'(match_done), 32'(1'b0));
    check({tag, "_idle_busy"}, 32'(busy), 32'(1'b0));
    check({tag, "_champ_hold"}, 32'(champ), 32'(champ_m));
    check({tag, "_idle_freeze"}, 32'({cnt_init, cnt_val}), 32'({1'b1, cnt_count}));
  endtask

  // Runs one granted move from the ARB cycle; req stays held for the whole move.
  task automatic do_move(input logic [1:0] r, input logic [3:0] modes, input bit inj_go,
                         input bit go_ph, input logic [1:0] go_who, input bit poke_start,
                         output bit ended);
    int p;
    int m;
`ifdef FIXED_PRIO_EN
    p = r[0] ? 0 : 1;
`else
    p = (r == 2'b11) ? ptr_m : (r[1] ? 1 : 0);
`endif
    ptr_m  = 1 - p;
    last_p = p;
    m = (p == 1) ? int'(modes[3:2]) : int'(modes[1:0]);
    if (m == 0)      cnt_m = (cnt_m + 1) % 16;
    else if (m == 1) cnt_m = (cnt_m + 15) % 16;
    if (cnt_m == 15) begin
      if (p == 1) s1_m = sat(s1_m + 1); else s0_m = sat(s0_m + 1);
    end else if (cnt_m == 0) begin
      if (p == 1) s1_m = sat(s1_m - 1); else s0_m = sat(s0_m - 1);
    end
    moves_m++;
    ended = inj_go || (moves_m == MAX_MOVES);
    if (inj_go) champ_m = champ_by_who(go_who, p);
    else if (ended) champ_m = (s0_m > s1_m) ? 2'b01 : (s1_m > s0_m) ? 2'b10 : 2'b11;

    req = r;
    req_mode = modes;
    #1;
    check("gnt", 32'(gnt), (p == 1) ? 32'h2 : 32'h1);
    check("arb_freeze_mv", 32'({cnt_init, cnt_val}), 32'({1'b1, cnt_count}));
    tick();
    check("step_init", 32'(cnt_init), 32'(1'b0));
    check("step_ctrl", 32'(cnt_ctrl), 32'(m));
    check("step_gnt", 32'(gnt), 32'h0);
    tick();
    check("count", 32'(cnt_count), 32'(cnt_m));
    check("wait1_init", 32'(cnt_init), 32'(1'b1));
    check("wait1_gnt", 32'(gnt), 32'h0);
    if (inj_go && !go_ph) begin gameover = 1'b1; who = go_who; end
    if (poke_start) start = 1'b1;
    tick();
    gameover = 1'b0;
    start = 1'b0;
    check("wait2_gnt", 32'(gnt), 32'h0);
    if (inj_go && go_ph) begin gameover = 1'b1; who = go_who; end
    tick();
    gameover = 1'b0;
    check("score0", 32'(score0), 32'(s0_m));
    check("score1", 32'(score1), 32'(s1_m));
    check("busy_mv", 32'(busy), 32'(1'b1));
    if (ended) finish_match("end");
    else check("no_done", 32'(match_done), 32'(1'b0));
  endtask

  // Gameover arriving while the sequencer sits in ARB with no request pending.
  task automatic arb_gameover(input logic [1:0] w);
    champ_m  = champ_by_who(w, last_p);
    req      = 2'b00;
    gameover = 1'b1;
    who      = w;
    #1;
    check("arb_go_gnt", 32'(gnt), 32'h0);
    tick();
    gameover = 1'b0;
    finish_match("arb_go");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bit ended;

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_init_val", 32'({cnt_init, cnt_val}), 32'({1'b1, 4'h0}));
    check("rst_ctrl", 32'(cnt_ctrl), 32'h0);
    check("rst_busy_done", 32'({busy, match_done}), 32'h0);
    check("rst_champ", 32'(champ), 32'h0);
    check("rst_scores", {16'h0, 8'(score0), 8'(score1)}, 32'h0);
    rst = 1'b0;
    model_reset();
    tick();

    // Both players requesting for a full match: alternating grants, ends on the move limit as a tie.
    start_match(4'h3);
    for (int i = 0; i < MAX_MOVES; i++)
      do_move(2'b11, 4'b0100, 1'b0, 1'b0, 2'b00, i == 1, ended);

    // Winner credited once, loser at zero saturates, gameover beats the move limit.
    start_match(4'hE);
    do_move(2'b01, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, ended);
    do_move(2'b10, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, ended);
    do_move(2'b10, 4'b1000, 1'b0, 1'b0, 2'b00, 1'b0, ended);
    do_move(2'b10, 4'b1000, 1'b1, 1'b0, 2'b01, 1'b1, ended);

    // Reset in the middle of a move aborts the match silently.
    start_match(4'hE);
    do_move(2'b01, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, ended);
    req = 2'b01;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b00;
    model_reset();
    check("abort_busy", 32'(busy), 32'(1'b0));
    check("abort_done", 32'(match_done), 32'(1'b0));
    check("abort_scores", {16'h0, 8'(score0), 8'(score1)}, 32'h0);
    check("abort_count", 32'(cnt_count), 32'h0);
    tick();
    check("abort_done2", 32'({busy, match_done}), 32'h0);

    // Randomized matches.
    for (int mt = 0; mt < 30; mt++) begin
      start_match(4'($urandom_range(0, 15)));
      ended = 1'b0;
      while (!ended) begin
        if ($urandom_range(0, 15) == 0) begin
          arb_gameover($urandom_range(0, 1) == 0 ? 2'b01 : 2'b10);
          ended = 1'b1;
        end else begin
          do_move(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) == 0 ? 2'b01 : 2'b10,
                  $urandom_range(0, 5) == 0, ended);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_match_sequencer.md
Name: counter_match_sequencer

Overview:
- Controller that sequences one shared up/down counter, plus its win/lose match tracker, between two players.
- Arbitrates player move requests and issues exactly one counter step per granted move.
- Freezes the counter between moves, seeds it at match start, and credits winner/loser events to the moving player.
- Ends the match on tracker gameover or on a move limit.

Parameters:
- N, 4, counter width (matches counter datapath width).
- MAX_MOVES, 64, move limit per match; reaching it ends the match.
- SCORE_W, 8, width of per-player score registers.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a match (accepted only in IDLE).
- seed  in  N  value loaded into the counter at match start.
- req  in  2  move request, bit p = player p; level, held until granted.
- req_mode  in  4  [1:0] player 0 ctrl code, [3:2] player 1 ctrl code.
- gnt  out  2  one-hot grant pulse, 1 cycle.
- cnt_init  out  1  counter load enable.
- cnt_val  out  N  counter load value.
- cnt_ctrl  out  2  counter ctrl code.
- cnt_count  in  N  current counter value.
- winner  in  1  counter all-ones flag.
- loser  in  1  counter all-zeros flag.
- gameover  in  1  match tracker gameover pulse.
- who  in  2  match tracker result (01 win, 10 lose).
- busy  out  1  high in every state except IDLE.
- match_done  out  1  1-cycle pulse on match end.
- champ  out  2  01 player 0, 10 player 1, 11 tie; held until next start.
- score0  out  SCORE_W  player 0 credited wins minus losses, saturating at 0 and at max.
- score1  out  SCORE_W  player 1, same rules as score0.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - State IDLE.
  - gnt=0, cnt_init=1, cnt_val=0, cnt_ctrl=0.
  - busy=0, match_done=0, champ=0, score0=score1=0.
  - Move count=0, round-robin pointer=player 0.
  - Reset mid-match aborts the match with no match_done pulse.
- Freeze rule: in every state except LOAD and STEP, cnt_init=1 and cnt_val=cnt_count, so the counter holds its value.
- States:
  - IDLE:
    - start=1 -> LOAD.
    - Clear scores, move count and champ on that edge.
    - start in any other state is ignored.
  - LOAD:
    - cnt_init=1, cnt_val=seed for exactly 1 cycle -> ARB.
  - ARB:
    - If req != 0: select per arbitration, assert gnt for 1 cycle, latch the selected player's mode and id -> STEP.
    - If req == 0: stay in ARB.
    - If gameover is seen here: go to DONE.
  - STEP:
    - cnt_init=0, cnt_ctrl=latched mode for exactly 1 cycle.
    - Increment move count -> WAIT.
  - WAIT:
    - Lasts 2 cycles.
    - The first winner pulse seen in the window adds 1 to the latched player's score.
    - Otherwise, the first loser pulse seen in the window subtracts 1 from that score.
    - At most one credit per move; winner takes priority if both are seen.
    - gameover seen in WAIT -> DONE.
    - Else, move count == MAX_MOVES -> DONE.
    - Else -> ARB.
  - DONE:
    - match_done=1 for 1 cycle, then -> IDLE.
    - If ended by gameover: champ = latched player when who=01, the other player when who=10.
    - If ended by the move limit: champ = higher score, 11 if scores are equal.
    - gameover takes priority over the move limit in the same cycle.
- Arbitration: round-robin.
  - Pointer names the preferred player.
  - After a grant, the pointer moves to the other player.
  - A single requester is always granted.
- Latency:
  - start -> first gnt: 2 cycles minimum (LOAD, then ARB).
  - gnt -> next possible gnt: 4 cycles (STEP, WAIT x2, ARB).
- Arithmetic:
  - Scores saturate at 0 and at 2^SCORE_W-1.
  - Move count is 1 + clog2(MAX_MOVES) bits and never wraps.

Optional Feature:
- Macro: FIXED_PRIO_EN.
- Defined: player 0 always wins arbitration when both players request; the pointer is unused.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- rst=1 for 2 cycles, then start with seed=4'h3 -> cnt_init=1/cnt_val=3 for one cycle, busy=1; next cycle cnt_init=1/cnt_val=cnt_count (freeze).
- req=2'b11 held for 4 moves -> gnt sequence 01,10,01,10; each gnt followed by exactly one cycle of cnt_init=0 with that player's ctrl code; gnt-to-gnt spacing 4 cycles.
- seed=4'hE, player 0 mode=00 -> count becomes F, winner pulse in WAIT; score0=1, not 2, even though winner repeats during freeze.
- Player 1 with score1=0 drives count to 0 -> loser pulse; score1 stays 0 (saturation).
- gameover=1 with who=01 during WAIT after a player 1 move -> match_done pulse, champ=10, busy=0 next cycle; start pulsed during the match is ignored.
- MAX_MOVES=4, no winner/loser events -> after 4th move match_done pulse, champ=11; rst asserted mid-match in a separate run -> IDLE, scores 0, no match_done.
